// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 10-bit frame shift, ACK and timeout.
// Define PS2_HOST_TX_RETRY_EN to re-send the latched frame once after an ACK error or timeout.

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6500,
    parameter int TIMEOUT_CYCLES = 975000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_BIT     = 4'd9;
    localparam logic [3:0]      BIT_SAT      = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_clk_meta;
    logic            r_clk_sync;
    logic            r_clk_prev;
    logic            r_data_meta;
    logic            r_data_sync;
    logic [9:0]      r_frame;
    logic [3:0]      r_bit_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            r_data_oe;

    logic            w_fall;
    logic            w_timeout;
    logic            w_nack;
    logic            w_accept;
    logic            w_restart;
    logic            w_shift;
    logic            w_data_oe_next;

    // Synchronizers reset to the idle (released, high) line level so reset never fakes a fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling its pre-edge input.
            r_clk_meta  <= ps2_clk_i;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_fall    = r_clk_prev & ~r_clk_sync;
    assign w_timeout = (r_state != S_IDLE) && (r_to_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_to_cnt  <= '0;
            r_data_oe <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_data_oe <= w_data_oe_next;
            if (w_accept) begin
                r_frame <= {1'b1, ~^tx_data, tx_data};
            end
            if (w_accept || w_restart) begin
                r_bit_cnt <= '0;
            end else if (w_shift && (r_bit_cnt != BIT_SAT)) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            // The same counter times the inhibit phase, so it must restart at every inhibit entry.
            if (w_accept || w_restart) begin
                r_to_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_HOST_TX_RETRY_EN
    logic r_retry_used;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retry_used <= 1'b0;
        end else if (w_accept) begin
            r_retry_used <= 1'b0;
        end else if (w_restart) begin
            r_retry_used <= 1'b1;
        end
    end
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_next   = r_state;
        w_data_oe_next = r_data_oe;
        w_accept       = 1'b0;
        w_restart      = 1'b0;
        w_shift        = 1'b0;
        w_nack         = 1'b0;
        tx_done        = 1'b0;
        tx_ack_err     = 1'b0;
        tx_timeout     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_data_oe_next = 1'b0;
                if (tx_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (r_to_cnt == INHIBIT_LAST) begin
                    w_data_oe_next = 1'b1;
                    w_state_next   = S_REQ;
                end
            end
            S_REQ: begin
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (w_fall) begin
                    w_shift        = 1'b1;
                    w_data_oe_next = ~r_frame[r_bit_cnt];
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    if (r_data_sync) begin
                        w_nack = 1'b1;
                    end else begin
                        w_state_next = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (r_clk_sync && r_data_sync) begin
                    tx_done      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Failures override whatever the state decoded above, timeout first.
        if (w_timeout || w_nack) begin
            w_shift        = 1'b0;
            w_data_oe_next = 1'b0;
            tx_done        = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!r_retry_used) begin
                w_restart    = 1'b1;
                w_state_next = S_INHIBIT;
            end else begin
                w_state_next = S_IDLE;
                tx_timeout   = w_timeout;
                tx_ack_err   = ~w_timeout;
            end
`else
            w_state_next = S_IDLE;
            tx_timeout   = w_timeout;
            tx_ack_err   = ~w_timeout;
`endif
        end
    end

    assign tx_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_REQ);
    assign ps2_data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a wired-AND device model clocks frames out of the host and answers ACK.
// Expectations follow the build: PS2_HOST_TX_RETRY_EN switches the retry-dependent columns.

module tb_ps2_host_tx;

    localparam int INHIBIT = 100;
    localparam int TIMEOUT = 5000;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_ack_err;
    logic       tx_timeout;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;

    always #5 clk = ~clk;

    // Open-drain pads: either side pulling low wins.
    assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INHIBIT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event monitors, sampled on the falling edge.
    int n_done = 0, n_err = 0, n_tmo = 0, n_inh = 0, n_inh_bad = 0;
    int n_req = 0, n_acc = 0, n_rule_bad = 0, inh_run = 0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (tx_done)    n_done <= n_done + 1;
        if (tx_ack_err) n_err  <= n_err + 1;
        if (tx_timeout) n_tmo  <= n_tmo + 1;
        if (ps2_clk_oe && !ps2_data_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run != 0) begin
            n_inh   <= n_inh + 1;
            if (inh_run != INHIBIT) n_inh_bad <= n_inh_bad + 1;
            inh_run <= 0;
        end
        if (ps2_clk_oe && ps2_data_oe) n_req <= n_req + 1;
        if (tx_valid && tx_ready)      n_acc <= n_acc + 1;
        if ((int'(tx_done) + int'(tx_ack_err) + int'(tx_timeout) > 1) ||
            ((tx_done || tx_ack_err || tx_timeout) && !busy) ||
            (prev_pulse && !tx_ready))
            n_rule_bad <= n_rule_bad + 1;
        prev_pulse <= tx_done | tx_ack_err | tx_timeout;
    end

    typedef struct {
        logic [7:0] data;
        int         n_bad;     // attempts the device refuses to ACK
        logic       par;
        int         exp_done;
        int         exp_err;
        int         exp_inh;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One device-side attempt: clock out nfalls bits, then (for a full frame) the ACK clock.
    task automatic device_attempt(input bit ack_good, input int nfalls,
                                  output logic [10:0] bits, output bit ok);
        int guard = 0;
        bits = '0;
        ok   = 1'b1;
        while (!(busy && !ps2_clk_oe && ps2_data_oe) && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) begin
            ok = 1'b0;
            return;
        end
        repeat (20) tick();
        bits[0] = ps2_data_i;
        for (int i = 1; i <= nfalls; i++) begin
            dev_clk_low = 1'b1;
            repeat (20) tick();
            dev_clk_low = 1'b0;
            bits[i] = ps2_data_i;
            repeat (20) tick();
        end
        if (nfalls < 10) return;
        if (ack_good) dev_data_low = 1'b1;
        repeat (10) tick();
        dev_clk_low = 1'b1;
        repeat (20) tick();
        dev_clk_low = 1'b0;
        repeat (5) tick();
        dev_data_low = 1'b0;
        repeat (10) tick();
    endtask

    task automatic run_and_check(input vec_t v, input string tag);
        int s_done = n_done, s_err = n_err, s_tmo = n_tmo, s_inh = n_inh;
        int s_inh_bad = n_inh_bad, s_req = n_req, s_rule = n_rule_bad;
        int attempt = 0;
        bit ok;
        logic [10:0] bits = '0;
        tick();
        tx_data  = v.data;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        while (busy && attempt < 3) begin
            device_attempt(attempt >= v.n_bad, 10, bits, ok);
            check($sformatf("%s_dev_start", tag), ok, 1);
            attempt++;
        end
        repeat (5) tick();
        check($sformatf("%s_bits", tag), bits, {1'b1, v.par, v.data, 1'b0});
        check($sformatf("%s_done", tag), n_done - s_done, v.exp_done);
        check($sformatf("%s_ack_err", tag), n_err - s_err, v.exp_err);
        check($sformatf("%s_timeout", tag), n_tmo - s_tmo, 0);
        check($sformatf("%s_inhibits", tag), n_inh - s_inh, v.exp_inh);
        check($sformatf("%s_inhibit_len", tag), n_inh_bad - s_inh_bad, 0);
        check($sformatf("%s_req_cycles", tag), n_req - s_req, v.exp_inh);
        check($sformatf("%s_pulse_rules", tag), n_rule_bad - s_rule, 0);
        check($sformatf("%s_idle", tag), {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [10:0] bits;
        bit ok;
        int cnt;
        int s_done, s_err, s_tmo, s_inh, s_acc, s_rule;

        vecs[0] = '{8'hF4, 0, 1'b0, 1, 0, 1};
        vecs[1] = '{8'h00, 1, 1'b1, RETRY ? 1 : 0, RETRY ? 0 : 1, RETRY ? 2 : 1};
        vecs[2] = '{8'hA5, 0, 1'b1, 1, 0, 1};
        vecs[3] = '{8'h01, 2, 1'b0, 0, 1, RETRY ? 2 : 1};

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #12;
        check("reset_ready_busy", {tx_ready, busy}, 2'b10);
        check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("reset_pulses", {tx_done, tx_ack_err, tx_timeout}, 3'b000);
        tick();
        rst = 1'b1;
        repeat (3) tick();

        // Falls while idle must not start anything.
        s_done = n_done; s_err = n_err; s_tmo = n_tmo;
        for (int i = 0; i < 3; i++) begin
            dev_clk_low = 1'b1;
            repeat (5) tick();
            dev_clk_low = 1'b0;
            repeat (5) tick();
        end
        check("spurious_idle", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        check("spurious_pulses", (n_done - s_done) + (n_err - s_err) + (n_tmo - s_tmo), 0);

        for (int i = 0; i < 4; i++) begin
            run_and_check(vecs[i], $sformatf("vec%0d", i));
        end

        // tx_valid held with 0xFF across a 0xF4 transfer.
        s_done = n_done; s_acc = n_acc; s_err = n_err; s_rule = n_rule_bad;
        tick();
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        tick();
        tx_data = 8'hFF;
        device_attempt(1'b1, 10, bits, ok);
        check("held_dev_start0", ok, 1);
        check("held_bits_f4", bits, {1'b1, 1'b0, 8'hF4, 1'b0});
        check("held_ff_accepted", busy, 1);
        tx_valid = 1'b0;
        device_attempt(1'b1, 10, bits, ok);
        check("held_dev_start1", ok, 1);
        repeat (5) tick();
        check("held_bits_ff", bits, {1'b1, 1'b1, 8'hFF, 1'b0});
        check("held_done", n_done - s_done, 2);
        check("held_accepts", n_acc - s_acc, 2);
        check("held_ack_err", n_err - s_err, 0);
        check("held_pulse_rules", n_rule_bad - s_rule, 0);

        // Asynchronous reset after start + 4 data bits (data currently pulled low).
        tick();
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        device_attempt(1'b1, 4, bits, ok);
        check("rst_dev_start", ok, 1);
        check("rst_pre_state", {busy, ps2_clk_oe, ps2_data_oe}, 3'b101);
        #3;
        rst = 1'b0;
        #1;
        check("rst_async_release", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_and_check(vecs[0], "after_rst");

        // Device never clocks: timeout measured from the accepting edge.
        s_done = n_done; s_err = n_err; s_tmo = n_tmo; s_inh = n_inh;
        tick();
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (cnt == 1) tx_valid = 1'b0;
        end while (!tx_timeout && cnt < 12000);
        check("timeout_latency", cnt, RETRY ? 2 * TIMEOUT : TIMEOUT);
        tick();
        check("timeout_release", {tx_ready, busy, ps2_clk_oe, ps2_data_oe}, 4'b1000);
        repeat (3) tick();
        check("timeout_pulses", n_tmo - s_tmo, 1);
        check("timeout_no_other", (n_done - s_done) + (n_err - s_err), 0);
        check("timeout_inhibits", n_inh - s_inh, RETRY ? 2 : 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
